// File: rtl/spike_rate_decoder.sv
// Spike train decoder: windowed onset rate and, when SPIKE_RATE_DECODER_ISI_EN is
// defined, the inter-spike interval between the last two onsets.
module spike_rate_decoder #(
    parameter int WINDOW_LOG2 = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] spike,
    output logic [7:0] rate,
    output logic       rate_valid,
    output logic       rate_sat,
    output logic [7:0] isi,
    output logic       isi_valid
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        RUN        = 2'd2
    } state_t;

    localparam logic [WINDOW_LOG2-1:0] WIN_ONE = WINDOW_LOG2'(1);

    state_t                 state, state_nxt;
    logic [WINDOW_LOG2-1:0] win_cnt;
    logic [8:0]             onset_cnt;
    logic                   spike_d;
    logic                   spiking;
    logic                   active;
    logic                   onset;
    logic                   win_last;
    logic [9:0]             win_total;

    function automatic logic [8:0] sat_inc9(input logic [8:0] c, input logic inc);
        return (inc && (c != 9'h1FF)) ? c + 9'd1 : c;
    endfunction

    function automatic logic [7:0] sat_rate(input logic [9:0] t);
        return (t >= 10'd255) ? 8'd255 : t[7:0];
    endfunction

    assign spiking   = |spike;
    // Work only counts when enable is still high; a falling enable discards the cycle.
    assign active    = (state != IDLE) && enable;
    assign onset     = active && spiking && !spike_d;
    assign win_last  = &win_cnt;
    assign win_total = {1'b0, onset_cnt} + {9'd0, onset};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable) begin
`ifdef SPIKE_RATE_DECODER_ISI_EN
                    state_nxt = WAIT_FIRST;
`else
                    state_nxt = RUN;
`endif
                end
            end
`ifdef SPIKE_RATE_DECODER_ISI_EN
            WAIT_FIRST: begin
                if (!enable)    state_nxt = IDLE;
                else if (onset) state_nxt = RUN;
            end
`endif
            RUN: begin
                if (!enable) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !active) begin
            win_cnt   <= '0;
            onset_cnt <= '0;
            spike_d   <= 1'b0;
        end else begin
            win_cnt   <= win_cnt + WIN_ONE;
            spike_d   <= spiking;
            onset_cnt <= win_last ? 9'd0 : sat_inc9(onset_cnt, onset);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rate       <= '0;
            rate_sat   <= 1'b0;
            rate_valid <= 1'b0;
        end else begin
            rate_valid <= active && win_last;
            if (active && win_last) begin
                rate     <= sat_rate(win_total);
                rate_sat <= (win_total >= 10'd255);
            end
        end
    end

`ifdef SPIKE_RATE_DECODER_ISI_EN
    logic [7:0] isi_cnt;

    function automatic logic [7:0] sat_inc8(input logic [7:0] c);
        return (c != 8'hFF) ? c + 8'd1 : c;
    endfunction

    // isi_cnt holds the distance to the previous onset as seen in the current cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            isi       <= '0;
            isi_valid <= 1'b0;
            isi_cnt   <= '0;
        end else begin
            isi_valid <= onset && (state == RUN);
            if (!active) begin
                isi_cnt <= '0;
            end else if (onset) begin
                isi_cnt <= 8'd1;
                if (state == RUN) isi <= isi_cnt;
            end else if (state == RUN) begin
                isi_cnt <= sat_inc8(isi_cnt);
            end
        end
    end
`else
    assign isi       = 8'd0;
    assign isi_valid = 1'b0;
`endif

endmodule
